// File: rtl/vc_domain_arb2_pkg.sv
// Shared vc definitions: queue type constants, arbiter port indices and the
// two-input round-robin grant function used by vc_domain_arb2.
package vc_domain_arb2_pkg;

   localparam int VC_QUEUE_NORMAL = 0;
   localparam int VC_QUEUE_PIPE   = 1;
   localparam int VC_QUEUE_BYPASS = 2;

   localparam int VC_DOMAIN_ARB2_IN0 = 0;
   localparam int VC_DOMAIN_ARB2_IN1 = 1;

   // A lone valid wins outright; on a tie prio names the winner.
   function automatic logic [1:0] rr_grant(input logic [1:0] val, input logic prio);
      logic [1:0] g;
      if (val == 2'b11) g = prio ? 2'b10 : 2'b01;
      else              g = val;
      return g;
   endfunction

endpackage

// File: rtl/vc_rr_arb2.sv
// Two-input round-robin arbiter: priority pointer plus combinational grant.
// The pointer moves to the loser only when en signals an actual transfer.
module vc_rr_arb2
   import vc_domain_arb2_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] val,
   input  logic       en,
   output logic [1:0] grant
);

   logic prio_q, prio_d;

   always_comb begin
      grant  = rr_grant(val, prio_q);
      prio_d = prio_q;
      if (en && (grant != 2'b00)) prio_d = ~grant[VC_DOMAIN_ARB2_IN1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end

endmodule

// File: rtl/vc_domain_arb2.sv
// Two-producer merge into a single pipe-style output register carrying a domain bit.
// Optional macro VC_DOMAIN_ARB2_SWITCH_BUBBLE_EN inserts a bubble on domain switches.
module vc_domain_arb2
   import vc_domain_arb2_pkg::*;
#(
   parameter int p_msg_nbits = 8
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in0_val,
   output logic                   in0_rdy,
   input  logic                   in0_domain,
   input  logic [p_msg_nbits-1:0] in0_msg,
   input  logic                   in1_val,
   output logic                   in1_rdy,
   input  logic                   in1_domain,
   input  logic [p_msg_nbits-1:0] in1_msg,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic                   out_domain,
   output logic [p_msg_nbits-1:0] out_msg
);

   logic                   full_q, full_d;
   logic                   domain_q, domain_d;
   logic [p_msg_nbits-1:0] msg_q, msg_d;

   logic [1:0]             val;
   logic [1:0]             grant;
   logic                   load_ok;
   logic                   stall;
   logic                   xfer;
   logic                   win_domain;
   logic [p_msg_nbits-1:0] win_msg;

   assign val = {in1_val, in0_val};

   vc_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .val   (val),
      .en    (xfer),
      .grant (grant)
   );

   assign win_domain = grant[VC_DOMAIN_ARB2_IN1] ? in1_domain : in0_domain;
   assign win_msg    = grant[VC_DOMAIN_ARB2_IN1] ? in1_msg    : in0_msg;

`ifdef VC_DOMAIN_ARB2_SWITCH_BUBBLE_EN
   logic last_domain_q, last_domain_d;
   logic gap_q, gap_d;

   // A domain change may only load into a register that has been empty for a full cycle.
   assign stall = (grant != 2'b00) && (win_domain != last_domain_q) && !(!full_q && gap_q);

   always_comb begin
      gap_d         = ~full_q;
      last_domain_d = xfer ? win_domain : last_domain_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_domain_q <= 1'b0;
         gap_q         <= 1'b1;
      end else begin
         last_domain_q <= last_domain_d;
         gap_q         <= gap_d;
      end
   end
`else
   assign stall = 1'b0;
`endif

   assign load_ok = ~full_q | out_rdy;
   assign xfer    = (grant != 2'b00) && load_ok && !stall;

   // Gated by reset so the ready outputs are low while reset is held, clock or not.
   assign in0_rdy = grant[VC_DOMAIN_ARB2_IN0] & load_ok & ~stall & reset;
   assign in1_rdy = grant[VC_DOMAIN_ARB2_IN1] & load_ok & ~stall & reset;

   always_comb begin
      full_d   = full_q;
      msg_d    = msg_q;
      domain_d = domain_q;
      if (xfer) begin
         full_d   = 1'b1;
         msg_d    = win_msg;
         domain_d = win_domain;
      end else if (full_q && out_rdy) begin
         full_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q   <= 1'b0;
         msg_q    <= '0;
         domain_q <= 1'b0;
      end else begin
         full_q   <= full_d;
         msg_q    <= msg_d;
         domain_q <= domain_d;
      end
   end

   assign out_val    = full_q;
   assign out_msg    = msg_q;
   assign out_domain = domain_q;

endmodule

// File: tb/tb_vc_domain_arb2.sv
// Self-checking bench for vc_domain_arb2: vector tables with a message scoreboard,
// plus reset pulses; domain-switch expectations follow VC_DOMAIN_ARB2_SWITCH_BUBBLE_EN.
module tb_vc_domain_arb2;

   logic       clk;
   logic       reset;
   logic       in0_val, in0_rdy, in0_domain;
   logic [7:0] in0_msg;
   logic       in1_val, in1_rdy, in1_domain;
   logic [7:0] in1_msg;
   logic       out_val, out_rdy, out_domain;
   logic [7:0] out_msg;

   vc_domain_arb2 #(.p_msg_nbits(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in0_val    (in0_val),
      .in0_rdy    (in0_rdy),
      .in0_domain (in0_domain),
      .in0_msg    (in0_msg),
      .in1_val    (in1_val),
      .in1_rdy    (in1_rdy),
      .in1_domain (in1_domain),
      .in1_msg    (in1_msg),
      .out_val    (out_val),
      .out_rdy    (out_rdy),
      .out_domain (out_domain),
      .out_msg    (out_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v0;
      logic       d0;
      logic [7:0] m0;
      logic       v1;
      logic       d1;
      logic [7:0] m1;
      logic       ordy;
      logic       e_r0;
      logic       e_r1;
      logic       e_ov;
   } vec_t;

   typedef struct {
      logic       d;
      logic [7:0] m;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic v0, input logic d0, input logic [7:0] m0,
                               input logic v1, input logic d1, input logic [7:0] m1,
                               input logic ordy, input logic r0, input logic r1,
                               input logic ov);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.m0 = m0;
      v.v1 = v1; v.d1 = d1; v.m1 = m1;
      v.ordy = ordy; v.e_r0 = r0; v.e_r1 = r1; v.e_ov = ov;
      return v;
   endfunction

   function automatic vec_t idle(input logic ordy, input logic ov);
      return mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, ordy, 1'b0, 1'b0, ov);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Entered at posedge+1; leaves at the next posedge+1.
   task automatic run_vec(input vec_t v, input string tag);
      exp_t e;
      in0_val = v.v0; in0_domain = v.d0; in0_msg = v.m0;
      in1_val = v.v1; in1_domain = v.d1; in1_msg = v.m1;
      out_rdy = v.ordy;
      #3;
      chk({tag, ".in0_rdy"}, int'(in0_rdy), int'(v.e_r0));
      chk({tag, ".in1_rdy"}, int'(in1_rdy), int'(v.e_r1));
      chk({tag, ".out_val"}, int'(out_val), int'(v.e_ov));
      if (v.e_ov) begin
         if (sb.size() == 0) begin
            chk({tag, ".sb_nonempty"}, 0, 1);
         end else begin
            chk({tag, ".out_msg"},    int'(out_msg),    int'(sb[0].m));
            chk({tag, ".out_domain"}, int'(out_domain), int'(sb[0].d));
            if (v.ordy) void'(sb.pop_front());
         end
      end
      if (v.e_r0) begin e.d = v.d0; e.m = v.m0; sb.push_back(e); end
      if (v.e_r1) begin e.d = v.d1; e.m = v.m1; sb.push_back(e); end
      @(posedge clk);
      #1;
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("%s[%0d]", tag, i));
      chk({tag, ".sb_left"}, sb.size(), 0);
      tbl.delete();
   endtask

   // Entered at posedge+1: asserts reset mid-cycle, checks the immediate effect,
   // holds it across one edge with active inputs, releases between edges.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #2;
      chk({tag, ".rst_out_val"},    int'(out_val),    0);
      chk({tag, ".rst_in0_rdy"},    int'(in0_rdy),    0);
      chk({tag, ".rst_in1_rdy"},    int'(in1_rdy),    0);
      chk({tag, ".rst_out_msg"},    int'(out_msg),    0);
      chk({tag, ".rst_out_domain"}, int'(out_domain), 0);
      sb.delete();
      in0_val = 1'b1; in0_msg = 8'hEE; in1_val = 1'b1; in1_msg = 8'hDD; out_rdy = 1'b1;
      @(posedge clk);
      #2;
      chk({tag, ".rst_hold_out_val"}, int'(out_val), 0);
      in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      in0_val = 1'b1; in0_domain = 1'b0; in0_msg = 8'h5A;
      in1_val = 1'b1; in1_domain = 1'b0; in1_msg = 8'hA5;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      do_reset("init");

      // single producer, 1-cycle latency
      tbl.push_back(mk(1, 0, 8'hA5, 0, 0, 8'h00, 1, 1, 0, 0));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
      run_tbl("single");

      do_reset("r1");
      // both valid: strict alternation starting at in0
      tbl.push_back(mk(1, 0, 8'h11, 1, 0, 8'h22, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 8'h11, 1, 0, 8'h22, 1, 0, 1, 1));
      tbl.push_back(mk(1, 0, 8'h11, 1, 0, 8'h22, 1, 1, 0, 1));
      tbl.push_back(mk(1, 0, 8'h11, 1, 0, 8'h22, 1, 0, 1, 1));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
      run_tbl("alt");

      do_reset("r2");
      // backpressure then pop-and-load in one cycle
      tbl.push_back(mk(1, 0, 8'h33, 0, 0, 8'h00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h44, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h44, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h44, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h44, 1, 0, 1, 1));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
      run_tbl("bp");

      do_reset("r3");
      // reset while full: held message is discarded
      run_vec(mk(1, 0, 8'hC3, 0, 0, 8'h00, 0, 1, 0, 0), "mid.load");
      run_vec(idle(0, 1), "mid.held");
      do_reset("mid");
      run_vec(idle(1, 0), "mid.gone");
      // in1 only after release; prio returns to 0 so in0 wins the next tie
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h55, 1, 0, 1, 0));
      tbl.push_back(mk(1, 1, 8'h66, 1, 1, 8'h77, 1, 1, 0, 1));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
      run_tbl("post");

      do_reset("r4");
      // domain switch behind a popping domain-0 message
      tbl.push_back(mk(1, 0, 8'h81, 0, 0, 8'h00, 0, 1, 0, 0));
`ifdef VC_DOMAIN_ARB2_SWITCH_BUBBLE_EN
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h92, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h92, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h92, 1, 0, 1, 0));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
`else
      tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h92, 1, 0, 1, 1));
      tbl.push_back(idle(1, 1));
      tbl.push_back(idle(1, 0));
`endif
      run_tbl("dsw");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
